// File: rtl/lfsr6_pkg.sv
// rtl/lfsr6_pkg.sv - shared constants, state encoding and next-word law for the 6-bit Galois LFSR
package lfsr6_pkg;

    localparam int WIDTH = 6;
    localparam logic [WIDTH-1:0] TAP_MASK = 6'b001101;
    localparam logic [WIDTH-1:0] SEED = 6'h3F;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_t;

    // Shift left; when the MSB falls out, it is folded back into taps 0, 2 and 3.
    function automatic logic [WIDTH-1:0] lfsr6_nxt(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], 1'b0} ^ (w[WIDTH-1] ? TAP_MASK : '0);
    endfunction

endpackage

// File: rtl/popcnt6.sv
// rtl/popcnt6.sv - combinational population count of a 6-bit word
module popcnt6 (
    input  logic [5:0] data,
    output logic [2:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 6; i++) begin
            count = count + {2'b00, data[i]};
        end
    end

endmodule

// File: rtl/lfsr6_checker.sv
// rtl/lfsr6_checker.sv - locks onto a 6-bit LFSR word stream and counts mismatching words and bits
module lfsr6_checker
    import lfsr6_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_ERR = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             valid,
    input  logic [5:0]       data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_words,
    output logic [CNT_W-1:0] err_bits,
    output logic [CNT_W-1:0] word_cnt,
    output logic             zero_seen
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_ERR + 1);
    localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_LAST = BW'(UNLOCK_ERR);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  pred, pred_nxt;
    logic [GW-1:0]     good_cnt, good_nxt, good_inc;
    logic [BW-1:0]     bad_cnt, bad_nxt, bad_inc;
    logic              err_nxt, zero_nxt;
    logic [CNT_W-1:0]  err_words_nxt, err_bits_nxt, word_cnt_nxt;
    logic [CNT_W-1:0]  err_words_inc, word_cnt_inc, err_bits_add;
    logic [CNT_W:0]    err_bits_sum;
    logic [2:0]        diff_bits;
    logic              mismatch;

    popcnt6 u_popcnt (
        .data  (data ^ pred),
        .count (diff_bits)
    );

    // The all-zero word is the LFSR lockup state, so it never counts as a match.
    assign mismatch      = (data != pred) || (data == '0);
    assign good_inc      = good_cnt + 1'b1;
    assign bad_inc       = bad_cnt + 1'b1;
    assign err_words_inc = (err_words == '1) ? err_words : err_words + 1'b1;
    assign word_cnt_inc  = (word_cnt == '1) ? word_cnt : word_cnt + 1'b1;
    assign err_bits_sum  = {1'b0, err_bits} + (CNT_W + 1)'(diff_bits);
    assign err_bits_add  = err_bits_sum[CNT_W] ? '1 : err_bits_sum[CNT_W-1:0];

    always_comb begin
        state_nxt     = state;
        pred_nxt      = pred;
        good_nxt      = good_cnt;
        bad_nxt       = bad_cnt;
        err_nxt       = 1'b0;
        zero_nxt      = zero_seen;
        err_words_nxt = err_words;
        err_bits_nxt  = err_bits;
        word_cnt_nxt  = word_cnt;
        if (valid) begin
            if (data == '0) begin
                zero_nxt = 1'b1;
            end
            case (state)
                HUNT: begin
                    if (data != '0) begin
                        pred_nxt  = lfsr6_nxt(data);
                        good_nxt  = '0;
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (data == '0) begin
                        state_nxt = HUNT;
                    end else if (data == pred) begin
                        good_nxt = good_inc;
                        pred_nxt = lfsr6_nxt(data);
                        if (good_inc == LOCK_LAST) begin
                            state_nxt = LOCKED;
                            bad_nxt   = '0;
                        end
                    end else begin
                        pred_nxt = lfsr6_nxt(data);
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction free-runs so a corrupted word cannot derail it.
                    pred_nxt     = lfsr6_nxt(pred);
                    word_cnt_nxt = word_cnt_inc;
                    if (mismatch) begin
                        err_nxt       = 1'b1;
                        err_words_nxt = err_words_inc;
                        err_bits_nxt  = err_bits_add;
                        bad_nxt       = bad_inc;
                        if (bad_inc == UNLOCK_LAST) begin
                            state_nxt = HUNT;
                        end
                    end else begin
                        bad_nxt = '0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
        if (clr_cnt) begin
            err_words_nxt = '0;
            err_bits_nxt  = '0;
            word_cnt_nxt  = '0;
            zero_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= HUNT;
            pred      <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            zero_seen <= 1'b0;
            err_words <= '0;
            err_bits  <= '0;
            word_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pred      <= pred_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            locked    <= (state_nxt == LOCKED);
            err       <= err_nxt;
            zero_seen <= zero_nxt;
            err_words <= err_words_nxt;
            err_bits  <= err_bits_nxt;
            word_cnt  <= word_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr6_checker.sv
// tb/tb_lfsr6_checker.sv - scoreboard bench for lfsr6_checker with directed and random word streams
module tb_lfsr6_checker;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_ERR = 3;
    localparam int CNT_W      = 5;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             valid = 1'b0;
    logic [5:0]       data = '0;
    logic             clr_cnt = 1'b0;
    logic             locked, err, zero_seen;
    logic [CNT_W-1:0] err_words, err_bits, word_cnt;

    lfsr6_checker #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_ERR (UNLOCK_ERR),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .valid     (valid),
        .data      (data),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err       (err),
        .err_words (err_words),
        .err_bits  (err_bits),
        .word_cnt  (word_cnt),
        .zero_seen (zero_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int locked;
        int err;
        int ew;
        int eb;
        int wc;
        int zs;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_mis = 0;

    // Reference: mode 0 = searching, 1 = confirming, 2 = locked.
    int m_mode, m_pred, m_good, m_bad, m_ew, m_eb, m_wc, m_zs;
    int gen;

    function automatic int step(input int w);
        int s;
        s = (w * 2) % 64;
        if (w >= 32) s = s ^ 13;
        return s;
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        if (act != expv) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pred = 0; m_good = 0; m_bad = 0;
        m_ew = 0; m_eb = 0; m_wc = 0; m_zs = 0;
        gen = 63;
    endtask

    task automatic model(input bit v, input int d, input bit c);
        exp_t e;
        e.err = 0;
        if (v) begin
            if (d == 0) m_zs = 1;
            if (m_mode == 0) begin
                if (d != 0) begin m_pred = step(d); m_good = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == 0) m_mode = 0;
                else if (d == m_pred) begin
                    m_good++;
                    m_pred = step(d);
                    if (m_good == LOCK_CNT) begin m_mode = 2; m_bad = 0; end
                end else begin
                    m_pred = step(d);
                    m_good = 0;
                end
            end else begin
                m_wc = sat(m_wc + 1);
                if (d != m_pred || d == 0) begin
                    e.err = 1;
                    m_ew = sat(m_ew + 1);
                    m_eb = sat(m_eb + $countones(d ^ m_pred));
                    m_bad++;
                    if (m_bad == UNLOCK_ERR) m_mode = 0;
                end else begin
                    m_bad = 0;
                end
                m_pred = step(m_pred);
            end
        end
        if (c) begin m_ew = 0; m_eb = 0; m_wc = 0; m_zs = 0; end
        e.locked = (m_mode == 2);
        e.ew = m_ew; e.eb = m_eb; e.wc = m_wc; e.zs = m_zs;
        q.push_back(e);
    endtask

    task automatic drive(input bit v, input int d, input bit c);
        @(negedge clk);
        valid = v; data = 6'(d); clr_cnt = c;
        model(v, d, c);
    endtask

    task automatic gen_word(input int corrupt, input bit c);
        drive(1'b1, gen ^ corrupt, c);
        gen = step(gen);
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_err_words"}, int'(err_words), 0);
        chk({tag, "_err_bits"}, int'(err_bits), 0);
        chk({tag, "_word_cnt"}, int'(word_cnt), 0);
        chk({tag, "_zero_seen"}, int'(zero_seen), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        valid = 1'b0; clr_cnt = 1'b0; rst_b = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            chk("locked", int'(locked), e.locked);
            chk("err", int'(err), e.err);
            chk("err_words", int'(err_words), e.ew);
            chk("err_bits", int'(err_bits), e.eb);
            chk("word_cnt", int'(word_cnt), e.wc);
            chk("zero_seen", int'(zero_seen), e.zs);
        end
    end

    initial begin
        int r, m;
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_b = 1'b1;

        repeat (8) gen_word(0, 1'b0);            // lock after the fifth word
        gen_word(6'h01, 1'b0);                   // single-bit error, stays locked
        repeat (2) gen_word(0, 1'b0);
        gen_word(6'h04, 1'b1);                   // clear collides with a mismatch
        gen_word(0, 1'b0);
        repeat (3) gen_word(6'h3F, 1'b0);        // three full-word errors drop lock
        repeat (2) gen_word(0, 1'b0);
        drive(1'b1, 0, 1'b0);                    // zero during confirmation
        repeat (6) gen_word(0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, int'($urandom_range(0, 63)), 1'b0);
            gen_word(0, 1'b0);
        end
        repeat (40) gen_word(0, 1'b0);           // word_cnt saturates
        repeat (3) gen_word(6'h3F, 1'b0);        // err_bits saturates
        repeat (7) gen_word(0, 1'b0);
        do_reset("mid_locked_reset");

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_reset");
            end else if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, int'($urandom_range(0, 63)), ($urandom_range(0, 49) == 0));
            end else begin
                r = int'($urandom_range(0, 99));
                m = int'($urandom_range(1, 63));
                if (r < 4) begin
                    drive(1'b1, 0, ($urandom_range(0, 49) == 0));
                    gen = step(gen);
                end else begin
                    gen_word((r < 12) ? m : 0, ($urandom_range(0, 49) == 0));
                end
            end
        end

        @(negedge clk);
        valid = 1'b0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/lfsr6_checker.md
# lfsr6_checker

Downstream consumer of the 6-bit Galois LFSR pattern generator used for self-test. Each valid cycle it takes the generator's parallel 6-bit state word, predicts the next word with the same feedback law, locks onto the sequence and counts errors. Status outputs feed the test controller's pass/fail logic.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive matching words needed in SYNC to declare lock (≥1)
- UNLOCK_ERR, 3: consecutive mismatching words in LOCKED that drop lock (≥1)
- CNT_W, 16: width of the error and word counters

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- valid  in  1  data is a new generator word this cycle
- data  in  6  generator state word q[5:0]
- clr_cnt  in  1  synchronous clear of word_cnt, err_words, err_bits, zero_seen
- locked  out  1  checker is in LOCKED
- err  out  1  one-cycle pulse: mismatch detected while LOCKED
- err_words  out  CNT_W  mismatching words while LOCKED, saturating
- err_bits  out  CNT_W  sum of popcount(data ^ pred) over those words, saturating
- word_cnt  out  CNT_W  valid words accepted while LOCKED, saturating
- zero_seen  out  1  sticky: valid word equal to 6'h00 was received

## Operation
- Next-state law, nxt(w): w'[0]=w[5]; w'[1]=w[0]; w'[2]=w[1]^w[5]; w'[3]=w[2]^w[5]; w'[4]=w[3]; w'[5]=w[4].
- Internal registers: pred[5:0], good_cnt, bad_cnt, state.
- FSM states HUNT, SYNC, LOCKED. Only cycles with valid=1 cause transitions; valid=0 holds everything except err, which returns to 0.
- HUNT: on valid with data≠0, pred←nxt(data), good_cnt←0, go to SYNC. On data=0, stay in HUNT.
- SYNC: data==pred: good_cnt+1, pred←nxt(data); when good_cnt reaches LOCK_CNT, go to LOCKED with bad_cnt←0. Mismatch: pred←nxt(data), good_cnt←0, stay in SYNC. On data=0, go to HUNT.
- LOCKED (flywheel): pred←nxt(pred) on every valid regardless of data. word_cnt+1.
  - Match: bad_cnt←0.
  - Mismatch: err pulse, err_words+1, err_bits+=popcount(data^pred), bad_cnt+1. When bad_cnt reaches UNLOCK_ERR, go to HUNT.
- data=0 on valid, in any state: zero_seen←1. The all-zero word is a lockup state, so in LOCKED it also counts as a mismatch.
- Counters saturate at all-ones and never wrap. err_bits saturates independently of err_words.
- If clr_cnt and an increment occur in the same cycle, clr_cnt wins: the counter becomes 0. clr_cnt does not affect state, pred, or locked.

## Timing
- Reset values: state=HUNT, locked=0, err=0, all counters 0, zero_seen=0, pred=0, good_cnt=0, bad_cnt=0.
- All outputs are registered.
- locked rises in the cycle after the valid word that makes good_cnt equal LOCK_CNT.
- locked falls in the cycle after the UNLOCK_ERR-th consecutive mismatch.
- err and counter updates appear in the cycle after the offending valid word.
- Minimum time to lock from reset: 1+LOCK_CNT valid words.
- Reset asserted mid-stream returns everything to reset values immediately (asynchronous). The first valid word after reset release is treated as in HUNT.
- The upstream generator resets to 6'h3F, so its first word after reset is 6'h3F.

## Structure
- Package lfsr6_pkg holds:
  - WIDTH=6
  - TAP_MASK=6'b001101
  - SEED=6'h3F
  - state enum {HUNT, SYNC, LOCKED}
  - function lfsr6_nxt, shared with the generator
- Sub-module popcnt6: combinational 6-bit popcount with a 3-bit result, instantiated for err_bits.

## Test plan
- Reset, then feed the generator sequence 3F, 33, 2B, 1B, 36, … with valid=1 and LOCK_CNT=4 -> locked=1 the cycle after the 5th word (36); err_words=0.
- While locked, replace an expected 2B with 2A -> one err pulse, err_words=1, err_bits=1, locked stays 1; the next correct word resets bad_cnt.
- While locked, send 3 consecutive words each XOR 6'h3F from expected -> err_bits=18, err_words=3, locked drops after the 3rd.
- Insert 6'h00 during SYNC -> state HUNT, zero_seen=1; reacquire from 33 and lock after 4 further matches.
- Assert clr_cnt on the same cycle as a mismatch -> err_words=0 and err_bits=0 next cycle, locked unchanged.
- Toggle valid every other cycle during lock -> identical counts to the continuous run; assert rst_b=0 mid-LOCKED -> all outputs return to 0 immediately.
